// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor family.
package cla_pkg;

  localparam int unsigned CLA_DEF_WIDTH  = 32;
  localparam int unsigned CLA_DEF_STAGES = 4;
  // Widest segment cla_seg_calc can evaluate.
  localparam int unsigned CLA_MAX_SEG    = 64;

  typedef struct packed {
    logic [CLA_DEF_WIDTH-1:0] sum;
    logic                     cout;
    logic                     ovf;
  } cla_result_t;

  // Returns {carry_out, sum}. Callers zero-extend narrower operands, so bit n of the
  // result carries the segment carry-out for an n-bit segment.
  function automatic logic [CLA_MAX_SEG:0] cla_seg_calc(input logic [CLA_MAX_SEG-1:0] a,
                                                        input logic [CLA_MAX_SEG-1:0] b,
                                                        input logic               c);
    logic [CLA_MAX_SEG-1:0] p;
    logic [CLA_MAX_SEG-1:0] g;
    logic [CLA_MAX_SEG:0]   cy;
    p     = a ^ b;
    g     = a & b;
    cy[0] = c;
    for (int i = 0; i < CLA_MAX_SEG; i++) begin
      cy[i+1] = g[i] | (p[i] & cy[i]);
    end
    return {cy[CLA_MAX_SEG], p ^ cy[CLA_MAX_SEG-1:0]};
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational generate/propagate lookahead adder for one SEG-bit segment.
module cla_segment
  import cla_pkg::*;
#(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] s,
  output logic           c_out,
  output logic           c_msb_in
);

  assign {c_out, s} = (SEG+1)'(cla_seg_calc(CLA_MAX_SEG'(a), CLA_MAX_SEG'(b), c_in));

  // sum_msb = p_msb ^ c_msb, so the carry into the MSB falls out of the sum bit.
  assign c_msb_in = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor, one WIDTH/STAGES-bit segment per stage, valid/ready flow.
// Define CLA_SATURATE_EN to clamp the signed result on overflow in the final stage.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = CLA_DEF_WIDTH,
  parameter int unsigned STAGES = CLA_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if ((STAGES == 0) || (WIDTH % STAGES != 0)) begin : gen_bad_split
    $error("pipelined_cla_addsub: WIDTH must be a nonzero multiple of STAGES");
  end
  if (SEG > CLA_MAX_SEG) begin : gen_bad_seg
    $error("pipelined_cla_addsub: segment wider than CLA_MAX_SEG");
  end

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic              ovf_q;
  // Skew (operands) and deskew (partial sums) registers, one per stage.
  logic [WIDTH-1:0]  opa_q  [STAGES];
  logic [WIDTH-1:0]  opb_q  [STAGES];
  logic [WIDTH-1:0]  psum_q [STAGES];

  logic [WIDTH-1:0]  stg_a   [STAGES];
  logic [WIDTH-1:0]  stg_b   [STAGES];
  logic [WIDTH-1:0]  stg_sum [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic [STAGES-1:0] stg_c;
  logic [STAGES-1:0] seg_co;
  logic              seg_cm  [STAGES];
  logic [SEG-1:0]    seg_s   [STAGES];
  logic              ovf_raw;
  logic [WIDTH-1:0]  res_sum;

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    stg_a[0]   = x;
    stg_b[0]   = sub ? ~y : y;
    stg_c[0]   = sub | cin;
    stg_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      stg_a[k]   = opa_q[k-1];
      stg_b[k]   = opb_q[k-1];
      stg_c[k]   = cy_q[k-1];
      stg_sum[k] = psum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_seg
    cla_segment #(
      .SEG(SEG)
    ) u_seg (
      .a       (stg_a[k][k*SEG +: SEG]),
      .b       (stg_b[k][k*SEG +: SEG]),
      .c_in    (stg_c[k]),
      .s       (seg_s[k]),
      .c_out   (seg_co[k]),
      .c_msb_in(seg_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_sum[k]                = stg_sum[k];
      nxt_sum[k][k*SEG +: SEG]  = seg_s[k];
    end
    ovf_raw = seg_co[STAGES-1] ^ seg_cm[STAGES-1];
    res_sum = nxt_sum[STAGES-1];
`ifdef CLA_SATURATE_EN
    // On overflow both conditioned sign bits agree, so either selects the clamp direction.
    if (ovf_raw) begin
      res_sum = stg_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k]  <= '0;
        opb_q[k]  <= '0;
        psum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k]  <= stg_a[k];
        opb_q[k]  <= stg_b[k];
        psum_q[k] <= nxt_sum[k];
        cy_q[k]   <= seg_co[k];
      end
      psum_q[STAGES-1] <= res_sum;
      ovf_q            <= ovf_raw;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = psum_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH 32, STAGES 4).
module tb_pipelined_cla_addsub;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int unsigned      cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  exp_t        sb[$];
  int unsigned n_cmp   = 0;
  int unsigned n_err   = 0;
  int unsigned cyc     = 0;
  bit          chk_lat = 1'b0;

  pipelined_cla_addsub #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH:0]   full;
    exp_t             e;
    bb     = s ? ~b : b;
    c0     = s ? 1'b1 : c;
    full   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c0);
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
`ifdef CLA_SATURATE_EN
    if (e.ovf) e.sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    e.cyc  = cyc;
    return e;
  endfunction

  // Outputs are popped before inputs are pushed: both transfers happen at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sum", sum, e.sum);
          check("cout", WIDTH'(cout), WIDTH'(e.cout));
          check("ovf", WIDTH'(ovf), WIDTH'(e.ovf));
          if (chk_lat) check("latency", cyc - e.cyc, STAGES);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(x, y, cin, sub));
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, input logic s);
    bit taken = 1'b0;
    x        = a;
    y        = b;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", WIDTH'(out_valid), 0);
    check("rst_sum", sum, 0);
    check("rst_cout", WIDTH'(cout), 0);
    check("rst_ovf", WIDTH'(ovf), 0);
    check("rst_in_ready", WIDTH'(in_ready), 1);
    @(posedge clk);
    #1;

    // Carry ripples across segment boundaries, signed overflow, subtracts.
    chk_lat = 1'b1;
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'd5, 32'd7, 1'b0, 1'b1);
    send(32'd7, 32'd5, 1'b1, 1'b1);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    drain();

    // Back-to-back random stream: latency check implies one result per clock.
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
    end
    drain();

    // Backpressure: stall the output for 3 cycles while the input keeps pushing.
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("stall_seen_valid", WIDTH'(seen), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", WIDTH'(in_ready), 0);
          check("stall_out_valid", WIDTH'(out_valid), 1);
          if (sb.size() != 0) check("stall_hold", sum, sb[0].sum);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight discards them.
    chk_lat = 1'b1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    send(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_out_valid", WIDTH'(out_valid), 0);
    end
    check("post_rst_in_ready", WIDTH'(in_ready), 1);
    @(posedge clk);
    #1;
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic library, and the successor to the single-cycle 8-bit combinational CLA.
- Splits a WIDTH-bit operation into STAGES equal segments, one segment per pipeline stage; the segment carry is registered between stages.
- Full throughput: one operation per clock.
- Valid/ready handshake on input and output, so it drops into vision pixel/accumulator datapaths with backpressure.

Parameters:
WIDTH, 32, operand and result width in bits
STAGES, 4, pipeline stages = segments; WIDTH % STAGES must be 0, otherwise elaboration error; SEG = WIDTH/STAGES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept beat this cycle
x  input  WIDTH  operand A
y  input  WIDTH  operand B
cin  input  1  carry-in, add mode only
sub  input  1  1 = x - y, 0 = x + y + cin
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (subtract: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock domain (clk); rst is synchronous and active-high.
- Reset values: all stage valid bits = 0; out_valid = 0; sum = 0; cout = 0; ovf = 0. in_ready = 1 in the cycle after rst deasserts.
- Transfers: input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
- Pipeline enable: adv = !out_valid || out_ready. The whole pipe shifts when adv = 1 and holds every register when adv = 0. in_ready = adv, combinational.
- Operand conditioning at capture: yb = sub ? ~y : y; c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1):
  - Computes segment k, bits [k*SEG +: SEG], with generate/propagate lookahead: c[i+1] = g[i] | p[i]&c[i], p = a^b, g = a&b.
  - Carry-in is the registered carry from stage k-1, or c0 for k = 0.
  - Not-yet-processed operand segments travel forward in skew registers.
  - Finished sum segments travel forward in deskew registers.
- Latency: STAGES cycles from input transfer to out_valid, with adv held 1. Bubbles are allowed: a stage valid bit of 0 propagates as a bubble.
- Outputs: sum, cout and ovf are registered at the last stage and stable while out_valid && !out_ready.
  - cout = carry out of the top segment.
  - ovf = carry into MSB XOR carry out of MSB.
- Ordering: results leave in input order; there is no reordering or dropping.
- Backpressure: out_ready = 0 with out_valid = 1 freezes all STAGES registers; the next accepted beat is the one that was pending. Up to STAGES beats are held in flight.
- Simultaneous events:
  - Output transfer and input accept in the same cycle is legal; throughput stays 1/clk.
  - rst has priority over every transfer.
- Reset mid-operation: all in-flight beats are discarded. No out_valid pulse follows reset until a new input transfer has completed STAGES cycles.
- STAGES = 1: degenerates to one registered CLA of WIDTH bits, latency 1.

Optional Feature:
CLA_SATURATE_EN
- Defined: the final stage clamps the signed result on ovf.
  - sum = 0x7F..F when the operands' sign bits (after conditioning) are 0.
  - sum = 0x80..0 when they are 1.
  - ovf still reports the raw overflow; cout is unaffected.
  - Adds no latency.
- Undefined: sum is the wrapped two's-complement result; the clamp logic is absent.

Decomposition:
- Shared package cla_pkg holds:
  - function cla_seg_calc(a, b, c) returning {carry_out, sum};
  - localparam defaults CLA_DEF_WIDTH = 32 and CLA_DEF_STAGES = 4;
  - a struct typedef cla_result_t {sum, cout, ovf} for downstream consumers.
- One combinational sub-module, cla_segment #(SEG): inputs a, b, c_in; outputs s, c_out, c_msb_in. c_msb_in is needed for ovf in the top segment. It is instantiated STAGES times in a generate loop.
- Pipeline control lives in the top module.

Test Plan:
1. WIDTH = 32, STAGES = 4, out_ready = 1. Add 0x0000_FFFF + 0x0000_0001, cin = 0 → 4 cycles later sum = 0x0001_0000, cout = 0, ovf = 0. The carry crosses segment boundaries at stages 1 and 2.
2. Add 0x7FFF_FFFF + 1 → sum = 0x8000_0000, ovf = 1. With CLA_SATURATE_EN: sum = 0x7FFF_FFFF, ovf = 1.
3. Subtract with sub = 1:
   - 5 - 7 → sum = 0xFFFF_FFFE, cout = 0.
   - 7 - 5 → sum = 2, cout = 1.
   - 0x8000_0000 - 1 → ovf = 1.
4. Stream 10 back-to-back random beats with out_ready = 1 → 10 results on consecutive cycles, in order, matching the reference model.
5. Stream beats while out_ready is held 0 for 3 cycles once out_valid = 1 → in_ready = 0 during the stall, sum is held stable, no beat is lost or duplicated, and order is preserved after release.
6. Assert rst for 1 cycle with 3 beats in flight → out_valid = 0 next cycle and stays 0. A fresh beat 0xFFFF_FFFF + 0, cin = 1 → sum = 0, cout = 1 after 4 cycles.
